mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single line-wide main-memory port between the instruction-cache fill path and the data-cache fill/writeback path.
- Registers a request, drives the memory's level Read/Write handshake until memory Ready, and returns the line.
- Issues a one-cycle ready pulse to the winning requester.
- Forces one idle cycle between transactions so the memory's latency pipeline clears.
- Sits between the two caches and the memory block.

Parameters:
- ADDR_W, 32, address width (WORD_SIZE)
- LINE_W, 128, cache line width (CACHE_LINE_SIZE)
- TIMEOUT, 64, max cycles a transaction may wait for mem_ready

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  icache line-fill request (level)
- i_addr  in  ADDR_W  icache fill address
- i_ready  out  1  one-cycle pulse, i_line valid
- i_line  out  LINE_W  returned icache line
- d_req  in  1  dcache request (level)
- d_we  in  1  1 = writeback, 0 = fill
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  LINE_W  writeback line
- d_ready  out  1  one-cycle pulse, transaction done
- d_line  out  LINE_W  returned dcache fill line
- mem_read  out  1  memory read, held until mem_ready
- mem_write  out  1  memory write, held until mem_ready
- mem_addr  out  ADDR_W  latched transaction address
- mem_wdata  out  LINE_W  latched write line
- mem_ready  in  1  memory done (level, stays high while Read/Write held)
- mem_line  in  LINE_W  memory read line
- err  out  1  sticky timeout flag

Behaviour:
- All outputs registered.
- Reset values:
  - state=IDLE
  - mem_read, mem_write, i_ready, d_ready, err = 0
  - mem_addr, mem_wdata, i_line, d_line = 0
  - last_grant=D, timeout counter=0
- Reset mid-transaction aborts immediately; no ready pulse is issued.
- FSM states: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE:
  - Only i_req: latch i_addr, go to BUSY_I, mem_read=1 from next cycle.
  - Only d_req: latch d_addr, d_wdata, d_we; go to BUSY_D with mem_read=!d_we, mem_write=d_we.
  - Both requests: grant the side not equal to last_grant (first conflict after reset goes to I); update last_grant on every grant.
- BUSY_I / BUSY_D:
  - Hold mem_read/mem_write, mem_addr, mem_wdata stable.
  - Counter increments each cycle.
  - On a sampled mem_ready=1:
    - Drop mem_read/mem_write.
    - On a read, latch mem_line into i_line or d_line.
    - Pulse the matching ready for exactly one cycle (the RELEASE cycle).
    - Go to RELEASE.
  - A write leaves d_line unchanged.
  - mem_ready is ignored in IDLE and RELEASE.
- Timeout: if the counter reaches TIMEOUT-1 without mem_ready:
  - Set err=1 (sticky until rst).
  - Drop mem_read/mem_write and go to RELEASE with no ready pulse.
  - Requester keeps req high and is re-arbitrated.
- RELEASE:
  - mem_read=mem_write=0 for exactly one cycle; counter cleared; go to IDLE.
  - Requests are not sampled in this cycle.
- Requester rules:
  - req, addr, wdata, we stay stable from assertion until its ready is seen.
  - req is deasserted at the edge ending the ready cycle.
  - An unchanged req in IDLE is treated as a new request.
- Latency: req sampled in IDLE at edge E0; mem_read high from E0.
  - Memory asserting mem_ready after N edges of Read gives mem_ready sampled at E0+N.
  - ready is high during the cycle after E0+N.
  - Minimum gap between consecutive grants is 1 RELEASE cycle plus 1 IDLE cycle.
- At most one of mem_read/mem_write is high. i_ready and d_ready are never high together.

Test Plan:
- i_req=1, i_addr=0x40, memory model with 10-edge latency and mem_line=0xAAAA..:
  - mem_read high for 10 cycles, mem_addr=0x40.
  - i_ready high for exactly 1 cycle, i_line=0xAAAA...
  - mem_read low for the RELEASE cycle.
- i_req and d_req (fill, 0x80) raised in the same cycle after reset:
  - I served first; D granted 2 cycles after i_ready; d_line=memory data at 0x80.
- Both requests held continuously for 4 transactions: grants alternate I, D, I, D; no cycle has both mem_read and mem_write.
- d_req=1, d_we=1, d_addr=0x100, d_wdata=0x1234..:
  - mem_write held with mem_wdata=0x1234.. until mem_ready.
  - d_ready pulses; d_line unchanged; mem_read stays 0.
- rst=1 for 1 cycle while BUSY_D is 5 cycles in: next cycle all outputs are 0 and state is IDLE. No d_ready pulse. After rst drops with d_req still high, the request is re-granted.
- Memory never asserts mem_ready and TIMEOUT=64:
  - After 64 BUSY cycles err=1 and mem_read drops; no i_ready.
  - err stays 1 through later successful transactions until rst.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared line-wide memory port between the icache fill path and the
// dcache fill/writeback path, with a forced release cycle between transactions.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_line,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_line,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_line,
    output logic              err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StBusyI   = 2'd1;
    localparam logic [1:0] StBusyD   = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [LINE_W-1:0] i_line_q, i_line_d;
    logic [LINE_W-1:0] d_line_q, d_line_d;
    logic              err_q, err_d;
    logic              grant_i, grant_d;

    // On a conflict the side that did not win last time is served.
    assign grant_i = i_req && (!d_req || last_d_q);
    assign grant_d = d_req && !grant_i;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_line_d    = i_line_q;
        d_line_d    = d_line_q;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (grant_i) begin
                    state_d     = StBusyI;
                    last_d_d    = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = i_addr;
                end else if (grant_d) begin
                    state_d     = StBusyD;
                    last_d_d    = 1'b1;
                    mem_read_d  = !d_we;
                    mem_write_d = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end
            StBusyI, StBusyD: begin
                if (mem_ready) begin
                    state_d     = StRelease;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (state_q == StBusyI) begin
                        i_line_d  = mem_line;
                        i_ready_d = 1'b1;
                    end else begin
                        if (mem_read_q) begin
                            d_line_d = mem_line;
                        end
                        d_ready_d = 1'b1;
                    end
                end else if (cnt_q == CntMax) begin
                    // Abandon the transaction; the requester is re-arbitrated later.
                    state_d     = StRelease;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                state_d     = StIdle;
                cnt_d       = '0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_d_q    <= 1'b1;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_line_q    <= '0;
            d_line_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_line_q    <= i_line_d;
            d_line_q    <= d_line_d;
            err_q       <= err_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_line    = i_line_q;
    assign d_line    = d_line_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected completions, a forked
// monitor pops and compares them whenever a ready pulse appears.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, d_req, d_we;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] d_wdata;
    logic         i_ready, d_ready, mem_read, mem_write, mem_ready, err;
    logic [127:0] i_line, d_line, mem_wdata, mem_line;
    logic [31:0]  mem_addr;

    int n_checks = 0;
    int n_fails  = 0;
    int lat      = 10;
    logic no_resp = 1'b0;
    int mcnt     = 0;

    typedef struct packed {
        logic         is_d;
        logic [127:0] line;
    } exp_t;
    exp_t sb_q[$];

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_line(d_line),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_line(mem_line), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        if (a == 32'h40) return {32{4'hA}};
        return {a, ~a, a ^ 32'hDEADBEEF, a + 32'h0F0F0F0F};
    endfunction

    // Memory model: ready once Read/Write has been held for lat edges.
    always @(posedge clk) begin
        if (mem_read || mem_write) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end
    assign mem_ready = (mem_read || mem_write) && !no_resp && (mcnt >= lat - 1);
    assign mem_line  = line_of(mem_addr);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [127:0] line);
        exp_t e;
        e.is_d = is_d;
        e.line = line;
        sb_q.push_back(e);
    endtask

    task automatic wait_rdy(input logic want_d, input logic [31:0] ea, input logic [127:0] ew,
                            output int rd, output int wr, output int bad);
        logic done;
        done = 1'b0;
        rd = 0; wr = 0; bad = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (mem_read) rd++;
            if (mem_write) wr++;
            if ((mem_read || mem_write) &&
                (mem_addr != ea || (mem_write && mem_wdata != ew))) bad++;
            if (want_d ? d_ready : i_ready) done = 1'b1;
        end
        if (!done) check("ready_wait_bound", 128'(0), 128'(1));
    endtask

    initial begin
        int rd, wr, bad, k, seen;
        logic done;
        logic prev_i, prev_d;
        exp_t e;

        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        fork
            begin : monitor
                prev_i = 1'b0;
                prev_d = 1'b0;
                forever begin
                    @(negedge clk);
                    if (mem_read || mem_write)
                        check("rw_exclusive", 128'(mem_read && mem_write), 128'(0));
                    if (i_ready || d_ready) begin
                        check("ready_exclusive", 128'(i_ready && d_ready), 128'(0));
                        check("ready_one_cycle", 128'((i_ready && prev_i) || (d_ready && prev_d)),
                              128'(0));
                        if (sb_q.size() == 0) begin
                            check("unexpected_ready", 128'(1), 128'(0));
                        end else begin
                            e = sb_q.pop_front();
                            check("ready_port_is_d", 128'(d_ready), 128'(e.is_d));
                            check("line", d_ready ? d_line : i_line, e.line);
                        end
                    end
                    prev_i = i_ready;
                    prev_d = d_ready;
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_readies", 128'({i_ready, d_ready}), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", mem_wdata, 128'(0));
        check("rst_i_line", i_line, 128'(0));
        check("rst_d_line", d_line, 128'(0));
        rst = 1'b0;

        // Single icache fill, 10-edge latency
        lat = 10;
        i_req = 1; i_addr = 32'h40;
        push(1'b0, {32{4'hA}});
        wait_rdy(1'b0, 32'h40, '0, rd, wr, bad);
        i_req = 0;
        check("t1_read_cycles", 128'(rd), 128'(10));
        check("t1_addr_held", 128'(bad), 128'(0));
        check("t1_release_read_low", 128'(mem_read), 128'(0));

        // Simultaneous requests straight after reset: I first, D two cycles after i_ready
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat = 3;
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h80;
        push(1'b0, {32{4'hA}});
        push(1'b1, line_of(32'h80));
        wait_rdy(1'b0, 32'h40, '0, rd, wr, bad);
        i_req = 0;
        k = 0;
        done = 1'b0;
        for (int i = 1; i <= 10 && !done; i++) begin
            @(negedge clk);
            if (mem_read) begin
                k = i;
                done = 1'b1;
            end
        end
        check("t2_d_grant_gap", 128'(k), 128'(2));
        check("t2_d_addr", 128'(mem_addr), 128'(32'h80));
        wait_rdy(1'b1, 32'h80, '0, rd, wr, bad);
        d_req = 0;

        // Both held for four transactions: strict alternation I, D, I, D
        lat = 4;
        i_addr = 32'h200; d_addr = 32'h300; d_we = 0;
        i_req = 1; d_req = 1;
        push(1'b0, line_of(32'h200));
        push(1'b1, line_of(32'h300));
        push(1'b0, line_of(32'h200));
        push(1'b1, line_of(32'h300));
        seen = 0;
        for (int i = 0; i < 500 && seen < 4; i++) begin
            @(negedge clk);
            if (i_ready || d_ready) seen++;
        end
        i_req = 0; d_req = 0;
        check("t3_completions", 128'(seen), 128'(4));

        // Writeback: mem_write only, d_line keeps last fill
        lat = 5;
        d_req = 1; d_we = 1; d_addr = 32'h100;
        d_wdata = {32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D, 32'hCAFEBABE};
        push(1'b1, line_of(32'h300));
        wait_rdy(1'b1, 32'h100, d_wdata, rd, wr, bad);
        d_req = 0;
        check("t4_write_cycles", 128'(wr), 128'(5));
        check("t4_no_read", 128'(rd), 128'(0));
        check("t4_addr_wdata_held", 128'(bad), 128'(0));

        // Reset five cycles into a dcache fill aborts it; the held request is re-granted
        lat = 20;
        d_req = 1; d_we = 0; d_addr = 32'h500;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (mem_read) done = 1'b1;
        end
        check("t5_granted", 128'(done), 128'(1));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_mem_read", 128'(mem_read), 128'(0));
        check("t5_rst_d_ready", 128'(d_ready), 128'(0));
        check("t5_rst_d_line", d_line, 128'(0));
        check("t5_rst_mem_addr", 128'(mem_addr), 128'(0));
        push(1'b1, line_of(32'h500));
        wait_rdy(1'b1, 32'h500, '0, rd, wr, bad);
        d_req = 0;
        check("t5_regrant_read_cycles", 128'(rd), 128'(20));

        // Timeout: no mem_ready for 64 busy cycles
        no_resp = 1'b1;
        i_req = 1; i_addr = 32'h600;
        rd = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (mem_read) rd++;
            else if (rd > 0) done = 1'b1;
        end
        check("t6_busy_cycles", 128'(rd), 128'(64));
        check("t6_err_set", 128'(err), 128'(1));
        check("t6_no_i_ready", 128'(i_ready), 128'(0));
        no_resp = 1'b0;
        lat = 3;
        push(1'b0, line_of(32'h600));
        wait_rdy(1'b0, 32'h600, '0, rd, wr, bad);
        i_req = 0;
        check("t6_err_sticky_i", 128'(err), 128'(1));
        lat = 2;
        d_req = 1; d_we = 0; d_addr = 32'h700;
        push(1'b1, line_of(32'h700));
        wait_rdy(1'b1, 32'h700, '0, rd, wr, bad);
        d_req = 0;
        check("t6_err_sticky_d", 128'(err), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_err_cleared", 128'(err), 128'(0));

        repeat (4) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
